// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus of the sequential restoring divider.
// The control unit drives the master side; the divider implements the slave side.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one shift + trial subtraction per cycle, WIDTH iterations.
// The trial subtraction A + ~M + 1 uses 4-bit carry-lookahead groups chained on group P/G.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GROUPS = WIDTH / 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, q_q, m_q;
  logic [CW-1:0]    cnt_q;
  logic             dz_q;
  logic             busy_q, done_q, div_by_zero_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  // Returns {group G, group P, 4-bit sum}; carries inside the group are fully expanded.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
    logic [3:0] g, p, c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
            &p, p ^ c};
  endfunction

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] m_inv, diff_lo, a_next;
  logic [GROUPS:0]  gc;
  logic [5:0]       grp;
  logic             no_borrow;

  assign a_sh  = {a_q, q_q[WIDTH-1]};
  assign m_inv = ~m_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gc      = '0;
    diff_lo = '0;
    grp     = '0;
    gc[0]   = 1'b1;
    for (int j = 0; j < GROUPS; j++) begin
      grp              = cla4(a_sh[4*j +: 4], m_inv[4*j +: 4], gc[j]);
      diff_lo[4*j +: 4] = grp[3:0];
      gc[j+1]          = grp[5] | (grp[4] & gc[j]);
    end
  end

  // Bit WIDTH of the extended subtrahend is 1, so its carry-out reduces to a_top | carry_in.
  assign no_borrow = a_sh[WIDTH] | gc[GROUPS];
  assign a_next    = no_borrow ? diff_lo : a_sh[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      q_q           <= '0;
      m_q           <= '0;
      cnt_q         <= '0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start overlapping the completion pulse is dropped, not queued.
          if (bus.start && !done_q) begin
            m_q   <= bus.divisor;
            q_q   <= bus.dividend;
            a_q   <= '0;
            cnt_q <= '0;
            if (bus.divisor == '0) begin
              dz_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              dz_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          a_q   <= a_next;
          q_q   <= {q_q[WIDTH-2:0], no_borrow};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q        <= 1'b1;
          quotient_q    <= dz_q ? '1 : q_q;
          remainder_q   <= dz_q ? q_q : a_q;
          div_by_zero_q <= dz_q;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_seq_restoring_divider;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares results on done, checks single-cycle done and output stability.
  logic             prev_done = 1'b0;
  logic [2*WIDTH:0] last_out  = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_out  = {bus.quotient, bus.remainder, bus.div_by_zero};
        prev_done = 1'b0;
      end else begin
        if (bus.done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'(bus.done), 64'(0));
          end else begin
            e = sb.pop_front();
            check("quotient", 64'(bus.quotient), 64'(e.q));
            check("remainder", 64'(bus.remainder), 64'(e.r));
            check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
          end
          check("done_single_cycle", 64'(prev_done), 64'(0));
          last_out = {bus.quotient, bus.remainder, bus.div_by_zero};
        end else begin
          check("outputs_stable", 64'({bus.quotient, bus.remainder, bus.div_by_zero}), 64'(last_out));
        end
        prev_done = bus.done;
      end
    end
  end

  // Issues one operation; optionally pulses a competing start in RUN cycle spoil_at
  // and/or during the done cycle. Checks latency and busy duration.
  task automatic op(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                    input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er, input logic edz,
                    input int spoil_at, input bit spoil_done);
    int lat;
    int nb;
    sb.push_back('{q: eq, r: er, dz: edz});
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    nb  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == spoil_at) begin
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
      end else if (bus.start) begin
        bus.start = 1'b0;
      end
      if (bus.busy) nb++;
      if (bus.done) begin
        lat = i - 1;
        break;
      end
    end
    if (spoil_done) begin
      bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("latency", 64'(lat), 64'(edz ? 1 : WIDTH + 1));
    check("busy_cycles", 64'(nb), 64'(edz ? 0 : WIDTH));
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    bit saw_busy;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_results", 64'({bus.quotient, bus.remainder, bus.div_by_zero}), 64'(0));
    rst_n = 1'b1;

    op(8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 0, 1'b0);
    op(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 0, 1'b0);
    op(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 0, 1'b0);
    op(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 0, 1'b0);
    op(8'd77,  8'd0,   8'hFF,  8'd77, 1'b1, 0, 1'b0);
    op(8'd10,  8'd3,   8'd3,   8'd1,  1'b0, 0, 1'b0);

    // Competing starts in RUN and during the done pulse must be dropped.
    op(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 3, 1'b1);
    saw_busy = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (bus.busy) saw_busy = 1'b1;
    end
    check("no_restart", 64'(saw_busy), 64'(0));

    // Reset in the middle of RUN aborts without a done pulse.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_results", 64'({bus.quotient, bus.remainder, bus.div_by_zero}), 64'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 64'(sb.size()), 64'(0));
    op(8'd60, 8'd8, 8'd7, 8'd4, 1'b0, 0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      a = WIDTH'($urandom);
      b = (k % 16 == 0) ? '0 : WIDTH'($urandom_range(0, (k % 3 == 0) ? 15 : 255));
      if (b == '0) op(a, b, '1, a, 1'b1, 0, 1'b0);
      else         op(a, b, a / b, a % b, 1'b0, 0, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
